// File: rtl/dmem_mmio_bridge.sv
// Data-side bridge between the processor dmem port and the dmem syncram.
// Adds an MMIO window (out regs, synchronised in regs, cycle counter) and a stalled read path.
module dmem_mmio_bridge #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE   = 12'hF00,
    parameter int                    NUM_OUT     = 4,
    parameter int                    NUM_IN      = 4,
    parameter int                    MEM_LATENCY = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         proc_req,
    input  logic [ADDR_WIDTH-1:0]        proc_address,
    input  logic [DATA_WIDTH-1:0]        proc_data,
    input  logic                         proc_wren,
    output logic [DATA_WIDTH-1:0]        proc_q,
    output logic                         proc_stall,
    output logic [ADDR_WIDTH-1:0]        mem_address,
    output logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         mem_wren,
    input  logic [DATA_WIDTH-1:0]        mem_q,
    output logic [NUM_OUT*DATA_WIDTH-1:0] io_out,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  io_in,
    output logic [DATA_WIDTH-1:0]        cycle_count
);
    // state | meaning
    // IDLE  | no dmem read in flight; dmem writes and MMIO accesses complete here
    // WAIT  | dmem read issued, latency counter running down, processor stalled
    // DONE  | captured read data presented on proc_q, stall released
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int                    LAT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] IN_OFS  = ADDR_WIDTH'(NUM_OUT);
    localparam logic [ADDR_WIDTH-1:0] CNT_OFS = ADDR_WIDTH'(NUM_OUT + NUM_IN);

    state_t                  state, state_nxt;
    logic [LAT_W-1:0]        lat_cnt, lat_nxt;
    logic [DATA_WIDTH-1:0]   rdata, rdata_nxt;
    logic                    stall;
    logic [DATA_WIDTH-1:0]   out_regs [NUM_OUT];
    logic [NUM_IN*DATA_WIDTH-1:0] in_meta, in_sync;
    logic [DATA_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   mmio_rdata;
    logic                    dmem_sel, rd_req, wr_req, cnt_clr;
    logic [ADDR_WIDTH-1:0]   mmio_ofs;

    assign dmem_sel    = proc_address < MMIO_BASE;
    assign mmio_ofs    = proc_address - MMIO_BASE;
    assign rd_req      = proc_req & ~proc_wren;
    assign wr_req      = proc_req & proc_wren;
    assign cnt_clr     = wr_req & ~dmem_sel & (mmio_ofs == CNT_OFS);

    assign mem_address = proc_address;
    assign mem_data    = proc_data;
    assign mem_wren    = wr_req & dmem_sel & (state == IDLE) & ~reset;
    assign cycle_count = cnt;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_io_out
        assign io_out[k*DATA_WIDTH +: DATA_WIDTH] = out_regs[k];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_OUT; k++) out_regs[k] <= '0;
        end else if (wr_req && !dmem_sel) begin
            for (int k = 0; k < NUM_OUT; k++)
                if (mmio_ofs == ADDR_WIDTH'(k)) out_regs[k] <= proc_data;
        end
    end

    // io_in is asynchronous to clock; only the second flop is ever observed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_meta <= '0;
            in_sync <= '0;
        end else begin
            in_meta <= io_in;
            in_sync <= in_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else              cnt <= cnt + 1'b1;
    end

    always_comb begin
        mmio_rdata = '0;
        for (int k = 0; k < NUM_OUT; k++)
            if (mmio_ofs == ADDR_WIDTH'(k)) mmio_rdata = out_regs[k];
        for (int k = 0; k < NUM_IN; k++)
            if (mmio_ofs == IN_OFS + ADDR_WIDTH'(k)) mmio_rdata = in_sync[k*DATA_WIDTH +: DATA_WIDTH];
        if (mmio_ofs == CNT_OFS) mmio_rdata = cnt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            rdata   <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            rdata   <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        rdata_nxt = rdata;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req && dmem_sel) begin
                    stall     = 1'b1;
                    lat_nxt   = LAT_W'(MEM_LATENCY - 1);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A withdrawn request abandons the read without touching rdata.
                if (!proc_req) begin
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                    if (lat_cnt == '0) begin
                        rdata_nxt = mem_q;
                        state_nxt = DONE;
                    end else begin
                        lat_nxt = lat_cnt - 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign proc_stall = stall & ~reset;

    always_comb begin
        proc_q = '0;
        if (reset)                        proc_q = '0;
        else if (state == DONE)           proc_q = rdata;
        else if (rd_req && !dmem_sel)     proc_q = mmio_rdata;
    end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: one instance at latency 1, one at latency 3,
// each with a small syncram model behind it.
module tb_dmem_mmio_bridge;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Latency-1 instance
    logic         req1, wren1, stall1, mwren1;
    logic [11:0]  addr1, maddr1;
    logic [31:0]  wdata1, q1, mdata1, mq1, cnt1;
    logic [127:0] io_out1, io_in1;
    logic [31:0]  mem1 [0:4095];

    dmem_mmio_bridge dut1 (
        .clock(clock), .reset(reset),
        .proc_req(req1), .proc_address(addr1), .proc_data(wdata1), .proc_wren(wren1),
        .proc_q(q1), .proc_stall(stall1),
        .mem_address(maddr1), .mem_data(mdata1), .mem_wren(mwren1), .mem_q(mq1),
        .io_out(io_out1), .io_in(io_in1), .cycle_count(cnt1)
    );

    always @(posedge clock) begin
        if (mwren1) mem1[maddr1] <= mdata1;
        mq1 <= mem1[maddr1];
    end

    // Latency-3 instance
    logic         req3, wren3, stall3, mwren3;
    logic [11:0]  addr3, maddr3;
    logic [31:0]  wdata3, q3, mdata3, mq3, cnt3, p0_3, p1_3;
    logic [127:0] io_out3;
    logic [127:0] io_in3 = '0;
    logic [31:0]  mem3 [0:4095];

    dmem_mmio_bridge #(.MEM_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .proc_req(req3), .proc_address(addr3), .proc_data(wdata3), .proc_wren(wren3),
        .proc_q(q3), .proc_stall(stall3),
        .mem_address(maddr3), .mem_data(mdata3), .mem_wren(mwren3), .mem_q(mq3),
        .io_out(io_out3), .io_in(io_in3), .cycle_count(cnt3)
    );

    always @(posedge clock) begin
        p0_3 <= mem3[maddr3];
        p1_3 <= p0_3;
        mq3  <= p1_3;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        req1 = 0; wren1 = 0; addr1 = '0; wdata1 = '0; io_in1 = '0;
        req3 = 0; wren3 = 0; addr3 = '0; wdata3 = '0;
        mem3[12'h020] = 32'hDEADBEEF;
        mem3[12'h021] = 32'h0000_0011;
        #3;
        check_val("rst_stall", stall1, 0);
        check_val("rst_q", q1, 0);
        check_val("rst_io_out", io_out1, 0);
        check_val("rst_cnt", cnt1, 0);
        step();
        reset = 1'b0;
        step();
        check_val("cnt_first_edge", cnt1, 1);

        // dmem write then read, latency 1
        req1 = 1; wren1 = 1; addr1 = 12'h010; wdata1 = 32'h1234;
        #1;
        check_val("wr_mem_wren", mwren1, 1);
        check_val("wr_no_stall", stall1, 0);
        check_val("wr_mem_addr", maddr1, 12'h010);
        check_val("wr_mem_data", mdata1, 32'h1234);
        step();
        wren1 = 0;
        #1;
        check_val("rd_wren_low", mwren1, 0);
        check_val("rd_stall_idle", stall1, 1);
        n = 0;
        while (stall1 && n < 20) begin step(); n++; end
        check_val("rd1_stall_cycles", n, 2);
        check_val("rd1_q", q1, 32'h1234);
        req1 = 0;
        step();
        check_val("q_idle_zero", q1, 0);

        // MMIO output registers
        req1 = 1; wren1 = 1; addr1 = 12'hF02; wdata1 = 32'hA5;
        #1;
        check_val("mmio_wr_no_memwren", mwren1, 0);
        check_val("mmio_wr_no_stall", stall1, 0);
        step();
        check_val("io_out2", io_out1[95:64], 32'hA5);
        wren1 = 0;
        #1;
        check_val("mmio_rd_out2", q1, 32'hA5);
        check_val("mmio_rd_no_stall", stall1, 0);
        check_val("mmio_rd_no_memwren", mwren1, 0);
        wren1 = 1; addr1 = 12'hF00; wdata1 = 32'h5A;
        step();
        check_val("io_out0", io_out1[31:0], 32'h5A);
        check_val("io_out2_kept", io_out1[95:64], 32'hA5);

        // Input synchroniser
        wren1 = 0; addr1 = 12'hF05; io_in1[63:32] = 32'h77;
        #1;
        check_val("in1_edge0", q1, 0);
        step();
        check_val("in1_edge1", q1, 0);
        step();
        check_val("in1_edge2", q1, 32'h77);

        // Cycle counter clear and count
        wren1 = 1; addr1 = 12'hF08;
        step();
        check_val("cnt_cleared", cnt1, 0);
        wren1 = 0;
        #1;
        check_val("cnt_rd_clear", q1, 0);
        for (int i = 1; i <= 10; i++) begin
            step();
            check_val("cnt_rd_inc", q1, i);
        end

        // Unmapped addresses
        addr1 = 12'hF0A;
        #1;
        check_val("unmapped_f0a", q1, 0);
        addr1 = 12'hF09;
        #1;
        check_val("unmapped_f09", q1, 0);
        wren1 = 1; addr1 = 12'hF0A; wdata1 = 32'hFFFF;
        #1;
        check_val("unmapped_wr_memwren", mwren1, 0);
        step();
        check_val("unmapped_wr_io", io_out1[31:0], 32'h5A);
        req1 = 0; wren1 = 0;

        // Latency-3 instance
        req3 = 1; wren3 = 1; addr3 = 12'hF01; wdata3 = 32'h33;
        #1;
        check_val("l3_mem_data", mdata3, 32'h33);
        step();
        check_val("l3_io_out1", io_out3[63:32], 32'h33);
        wren3 = 0; addr3 = 12'h020;
        #1;
        check_val("l3_mem_addr", maddr3, 12'h020);
        check_val("l3_stall_idle", stall3, 1);
        n = 0;
        while (stall3 && n < 20) begin step(); n++; end
        check_val("l3_stall_cycles", n, 4);
        check_val("l3_q", q3, 32'hDEADBEEF);
        req3 = 0;
        step();

        // Request withdrawn during WAIT
        req3 = 1; addr3 = 12'h021;
        step();
        req3 = 0;
        #1;
        check_val("l3_drop_stall", stall3, 0);
        step();
        check_val("l3_drop_q", q3, 0);
        req3 = 1;
        #1;
        n = 0;
        while (stall3 && n < 20) begin step(); n++; end
        check_val("l3_after_drop_cycles", n, 4);
        check_val("l3_after_drop_q", q3, 32'h11);
        req3 = 0;
        step();

        // Reset during WAIT
        req3 = 1; addr3 = 12'h020;
        step();
        check_val("l3_wait_stall", stall3, 1);
        reset = 1'b1;
        #1;
        check_val("l3_rst_stall", stall3, 0);
        check_val("l3_rst_q", q3, 0);
        check_val("l3_rst_io_out", io_out3, 0);
        check_val("l3_rst_cnt", cnt3, 0);
        wren3 = 1; addr3 = 12'h030;
        #1;
        check_val("l3_rst_no_memwren", mwren3, 0);
        wren3 = 0; addr3 = 12'h020;
        step();
        step();
        reset = 1'b0;
        #1;
        check_val("l3_post_rst_idle_stall", stall3, 1);
        n = 0;
        while (stall3 && n < 20) begin step(); n++; end
        check_val("l3_post_rst_cycles", n, 4);
        check_val("l3_post_rst_q", q3, 32'hDEADBEEF);
        req3 = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
